// File: rtl/irrigation_actuator.sv
// Responder-side irrigation sequencer: valve/pump control, run/complete handshake, humidity conditioning.
// Define IRRIG_DEBOUNCE_EN to debounce Hraw over DEB_LEN samples; otherwise H1 is a two-flop synchronized copy.
module irrigation_actuator #(
    parameter int OPEN_DLY  = 4,
    parameter int RUN_CYC   = 16,
    parameter int CLOSE_DLY = 4,
    parameter int DEB_LEN   = 3,
    parameter int CNT_W     = 8
) (
    input  logic Ck,
    input  logic Clr,
    input  logic St,
    input  logic S,
    input  logic Hraw,
    input  logic VFb,
    output logic H1,
    output logic R,
    output logic RC,
    output logic Valve,
    output logic Pump,
    output logic Fault
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPEN,
        ST_RUN,
        ST_CLOSE,
        ST_DONE,
        ST_FAULT
    } state_t;

    // Counter holds "remaining cycles after this one", so zero marks the last cycle of a state.
    localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'(OPEN_DLY - 1);
    localparam logic [CNT_W-1:0] RUN_LD   = CNT_W'(RUN_CYC - 1);
    localparam logic [CNT_W-1:0] CLOSE_LD = CNT_W'(CLOSE_DLY - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            Valve     <= 1'b0;
            Pump      <= 1'b0;
            R         <= 1'b0;
            RC        <= 1'b0;
            Fault     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (St) begin
                        state_reg <= ST_OPEN;
                        cnt_reg   <= OPEN_LD;
                        Valve     <= 1'b1;
                        R         <= 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (S) begin
                        state_reg <= ST_CLOSE;
                        cnt_reg   <= CLOSE_LD;
                        Valve     <= 1'b0;
                    end else if (cnt_reg == '0) begin
                        if (VFb) begin
                            state_reg <= ST_RUN;
                            cnt_reg   <= RUN_LD;
                            Pump      <= 1'b1;
                        end else begin
                            state_reg <= ST_FAULT;
                            cnt_reg   <= '0;
                            Valve     <= 1'b0;
                            R         <= 1'b0;
                            Fault     <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_RUN: begin
                    // Timeout, wet soil and abort all converge on the same drain sequence.
                    if (S || H1 || cnt_reg == '0) begin
                        state_reg <= ST_CLOSE;
                        cnt_reg   <= CLOSE_LD;
                        Valve     <= 1'b0;
                        Pump      <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_CLOSE: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_DONE;
                        cnt_reg   <= '0;
                        R         <= 1'b0;
                        RC        <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!St) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        RC        <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (S && !St) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        Fault     <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    Valve     <= 1'b0;
                    Pump      <= 1'b0;
                    R         <= 1'b0;
                    RC        <= 1'b0;
                    Fault     <= 1'b0;
                end
            endcase
        end
    end

`ifdef IRRIG_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_LEN - 1);

    logic [CNT_W-1:0] deb_cnt_reg;

    // Counts consecutive samples disagreeing with H1; any agreeing sample restarts the count.
    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            deb_cnt_reg <= '0;
            H1          <= 1'b0;
        end else if (Hraw != H1) begin
            if (deb_cnt_reg >= DEB_LAST) begin
                H1          <= Hraw;
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end else begin
            deb_cnt_reg <= '0;
        end
    end
`else
    logic sync_reg;

    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            sync_reg <= 1'b0;
            H1       <= 1'b0;
        end else begin
            sync_reg <= Hraw;
            H1       <= sync_reg;
        end
    end
`endif

endmodule

// File: tb/tb_irrigation_actuator.sv
// Randomized self-checking bench for irrigation_actuator against a phase/age reference model.
module tb_irrigation_actuator;

    localparam int OPEN_DLY  = 4;
    localparam int RUN_CYC   = 16;
    localparam int CLOSE_DLY = 4;
    localparam int DEB_LEN   = 3;
    localparam int CNT_W     = 8;

`ifdef IRRIG_DEBOUNCE_EN
    localparam int H1_LAT = DEB_LEN;
`else
    localparam int H1_LAT = 2;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_OPEN  = 1;
    localparam int M_RUN   = 2;
    localparam int M_CLOSE = 3;
    localparam int M_DONE  = 4;
    localparam int M_FAULT = 5;

    logic Ck = 1'b0;
    logic Clr = 1'b0;
    logic St = 1'b0;
    logic S = 1'b0;
    logic Hraw = 1'b0;
    logic VFb = 1'b1;
    logic H1, R, RC, Valve, Pump, Fault;

    irrigation_actuator #(
        .OPEN_DLY (OPEN_DLY),
        .RUN_CYC  (RUN_CYC),
        .CLOSE_DLY(CLOSE_DLY),
        .DEB_LEN  (DEB_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .Ck   (Ck),
        .Clr  (Clr),
        .St   (St),
        .S    (S),
        .Hraw (Hraw),
        .VFb  (VFb),
        .H1   (H1),
        .R    (R),
        .RC   (RC),
        .Valve(Valve),
        .Pump (Pump),
        .Fault(Fault)
    );

    always #5 Ck = ~Ck;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: current phase plus the index of the next edge spent in that phase.
    int   m_phase;
    int   m_age;
    logic m_h1;
    logic hist[$];

    task automatic model_reset();
        m_phase = M_IDLE;
        m_age   = 1;
        m_h1    = 1'b0;
        hist.delete();
`ifndef IRRIG_DEBOUNCE_EN
        hist.push_back(1'b0);
`endif
    endtask

    task automatic model_step();
        int nphase;
        bit all_differ;
        nphase = m_phase;
        case (m_phase)
            M_IDLE:  if (St) nphase = M_OPEN;
            M_OPEN:  if (S) nphase = M_CLOSE;
                     else if (m_age == OPEN_DLY) nphase = VFb ? M_RUN : M_FAULT;
            M_RUN:   if (S || m_h1 || m_age == RUN_CYC) nphase = M_CLOSE;
            M_CLOSE: if (m_age == CLOSE_DLY) nphase = M_DONE;
            M_DONE:  if (!St) nphase = M_IDLE;
            M_FAULT: if (S && !St) nphase = M_IDLE;
            default: nphase = M_IDLE;
        endcase
        m_age   = (nphase != m_phase) ? 1 : m_age + 1;
        m_phase = nphase;
`ifdef IRRIG_DEBOUNCE_EN
        hist.push_back(Hraw);
        if (hist.size() > DEB_LEN) void'(hist.pop_front());
        if (hist.size() == DEB_LEN) begin
            all_differ = 1'b1;
            foreach (hist[k]) if (hist[k] == m_h1) all_differ = 1'b0;
            if (all_differ) m_h1 = ~m_h1;
        end
`else
        all_differ = 1'b0;
        hist.push_back(Hraw);
        m_h1 = hist.pop_front();
`endif
    endtask

    task automatic check_all();
        check("valve", Valve, (m_phase == M_OPEN || m_phase == M_RUN));
        check("pump",  Pump,  (m_phase == M_RUN));
        check("run",   R,     (m_phase == M_OPEN || m_phase == M_RUN || m_phase == M_CLOSE));
        check("rc",    RC,    (m_phase == M_DONE));
        check("fault", Fault, (m_phase == M_FAULT));
        check("h1",    H1,    m_h1);
    endtask

    task automatic run_cycle();
        @(posedge Ck);
        model_step();
        @(negedge Ck);
        check_all();
    endtask

    // Called just after a negedge: assert reset between edges and check outputs clear at once.
    task automatic async_reset_pulse();
        #2;
        Clr = 1'b0;
        #1;
        check("arst_valve", Valve, 1'b0);
        check("arst_pump",  Pump,  1'b0);
        check("arst_run",   R,     1'b0);
        check("arst_rc",    RC,    1'b0);
        check("arst_fault", Fault, 1'b0);
        model_reset();
        @(negedge Ck);
        St  = 1'b0;
        S   = 1'b0;
        Clr = 1'b1;
    endtask

    task automatic go_idle();
        St   = 1'b0;
        S    = 1'b1;
        Hraw = 1'b0;
        VFb  = 1'b1;
        for (int k = 0; k < 60 && m_phase != M_IDLE; k++) run_cycle();
        S = 1'b0;
        repeat (DEB_LEN + 3) run_cycle();
    endtask

    int   e;
    int   pump_first;
    int   hraw_left = 0;
    logic hraw_val = 1'b0;

    task automatic drive_random();
        case (m_phase)
            M_IDLE: begin
                St = ($urandom_range(0, 3) == 0);
                S  = ($urandom_range(0, 7) == 0);
            end
            M_OPEN, M_RUN, M_CLOSE: begin
                St = 1'b1;
                S  = ($urandom_range(0, 39) == 0);
            end
            M_DONE: begin
                if ($urandom_range(0, 2) == 0) St = 1'b0;
                S = 1'b0;
            end
            default: begin
                St = ($urandom_range(0, 3) == 0);
                S  = ($urandom_range(0, 2) == 0);
            end
        endcase
        VFb = ($urandom_range(0, 9) != 0);
        if (hraw_left == 0) begin
            hraw_val  = ($urandom_range(0, 3) == 0);
            hraw_left = hraw_val ? $urandom_range(1, 8) : $urandom_range(1, 20);
        end
        Hraw = hraw_val;
        hraw_left--;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge Ck);
        check("reset_valve", Valve, 1'b0);
        check("reset_pump",  Pump,  1'b0);
        check("reset_run",   R,     1'b0);
        check("reset_rc",    RC,    1'b0);
        check("reset_fault", Fault, 1'b0);
        check("reset_h1",    H1,    1'b0);
        Clr = 1'b1;
        go_idle();

        // Nominal run: RC after edge 24, pump starts after edge OPEN_DLY
        St = 1'b1;
        run_cycle();
        e = 0;
        pump_first = -1;
        while (!RC && e < 60) begin
            run_cycle();
            e++;
            if (Pump && pump_first < 0) pump_first = e;
        end
        check("nominal_rc_edge", e, 24);
        check("nominal_pump_first", pump_first, OPEN_DLY);
        St = 1'b0;
        run_cycle();
        check("nominal_rc_fall", RC, 1'b0);
        go_idle();

        // Abort driven after edge 6: RC after edge 11
        St = 1'b1;
        run_cycle();
        repeat (6) run_cycle();
        S = 1'b1;
        e = 6;
        while (!RC && e < 60) begin
            run_cycle();
            e++;
        end
        check("abort_rc_edge", e, 11);
        go_idle();

        // Valve feedback failure
        St  = 1'b1;
        VFb = 1'b0;
        run_cycle();
        e = 0;
        while (!Fault && e < 20) begin
            run_cycle();
            e++;
        end
        check("fault_edge", e, OPEN_DLY);
        check("fault_valve", Valve, 1'b0);
        St = 1'b0;
        S  = 1'b1;
        run_cycle();
        check("fault_clear", Fault, 1'b0);
        go_idle();

        // Asynchronous reset mid-RUN, then a full restart
        St = 1'b1;
        run_cycle();
        repeat (10) run_cycle();
        async_reset_pulse();
        St = 1'b1;
        run_cycle();
        e = 0;
        while (!RC && e < 60) begin
            run_cycle();
            e++;
        end
        check("restart_rc_edge", e, 24);
        go_idle();

        // H1 latency and short glitches
        Hraw = 1'b1;
        e = 0;
        while (!H1 && e < 20) begin
            run_cycle();
            e++;
        end
        check("h1_latency", e, H1_LAT);
        Hraw = 1'b0;
        repeat (DEB_LEN + 3) run_cycle();
        Hraw = 1'b1; run_cycle();
        Hraw = 1'b0; repeat (3) run_cycle();
        Hraw = 1'b1; repeat (2) run_cycle();
        Hraw = 1'b0; repeat (4) run_cycle();
        go_idle();

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 1500; i++) begin
            drive_random();
            run_cycle();
            if ($urandom_range(0, 249) == 0) async_reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
